rect_index_gen: RTL and testbench

- LFSR-driven generator of rectangle-loop candidate coordinates (r1, c1, r2, c2) for the checkerboard-swap stage; sits directly upstream of it.
- Each issued tuple has r1 != r2, c1 != c2 and all indices in matrix range.
- Issues exactly a programmed number of tuples per run over a valid/ready handshake, then pulses done.
- Out-of-range or degenerate draws are rejected internally and counted.

---
 rtl/rect_index_gen.sv | 119 +++++++++++
 tb/tb_rect_index_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_index_gen.sv
// rect_index_gen: LFSR-driven generator of in-range rectangle index tuples with r1!=r2 and c1!=c2
module rect_index_gen #(
  parameter int MATRIX_ROW = 8,
  parameter int MATRIX_COL = 8,
  parameter int ROW_W = $clog2(MATRIX_ROW),
  parameter int COL_W = $clog2(MATRIX_COL),
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             start,
  input  logic [11:0]      iter_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] r1,
  output logic [COL_W-1:0] c1,
  output logic [ROW_W-1:0] r2,
  output logic [COL_W-1:0] c2,
  output logic             busy,
  output logic             done,
  output logic [15:0]      reject_cnt
);
  typedef enum logic [1:0] {IDLE, DRAW, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [11:0] issued_q, issued_d, target_q, target_d;
  logic [15:0] rej_q, rej_d;
  logic valid_q, valid_d, accept;
  logic [ROW_W-1:0] r1_q, r1_d, r2_q, r2_d, cr1, cr2;
  logic [COL_W-1:0] c1_q, c1_d, c2_q, c2_d, cc1, cc2;
  assign lfsr_adv = lfsr_q[0] ? (lfsr_q >> 1) ^ 32'h8020_0003 : lfsr_q >> 1;
  assign cr1 = lfsr_q[ROW_W-1:0];
  assign cc1 = lfsr_q[8+:COL_W];
  assign cr2 = lfsr_q[16+:ROW_W];
  assign cc2 = lfsr_q[24+:COL_W];
  assign accept = (32'(cr1) < MATRIX_ROW) && (32'(cr2) < MATRIX_ROW) &&
                  (32'(cc1) < MATRIX_COL) && (32'(cc2) < MATRIX_COL) &&
                  (cr1 != cr2) && (cc1 != cc2);
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    issued_d = issued_q;
    target_d = target_q;
    rej_d    = rej_q;
    valid_d  = valid_q;
    r1_d     = r1_q;
    c1_d     = c1_q;
    r2_d     = r2_q;
    c2_d     = c2_q;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed == '0) ? SEED : seed;
        end else if (start) begin
          rej_d    = '0;
          issued_d = '0;
          target_d = iter_count;
          state_d  = (iter_count == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        lfsr_d = lfsr_adv;
        if (accept) begin
          r1_d    = cr1;
          c1_d    = cc1;
          r2_d    = cr2;
          c2_d    = cc2;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          rej_d = (rej_q == 16'hFFFF) ? rej_q : rej_q + 16'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d  = 1'b0;
          issued_d = issued_q + 12'd1;
          state_d  = (issued_q + 12'd1 == target_q) ? DONE : DRAW;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      issued_q <= '0;
      target_q <= '0;
      rej_q    <= '0;
      valid_q  <= 1'b0;
      r1_q     <= '0;
      c1_q     <= '0;
      r2_q     <= '0;
      c2_q     <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      issued_q <= issued_d;
      target_q <= target_d;
      rej_q    <= rej_d;
      valid_q  <= valid_d;
      r1_q     <= r1_d;
      c1_q     <= c1_d;
      r2_q     <= r2_d;
      c2_q     <= c2_d;
    end
  end
  assign out_valid  = valid_q;
  assign r1         = r1_q;
  assign c1         = c1_q;
  assign r2         = r2_q;
  assign c2         = c2_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign reject_cnt = rej_q;
endmodule

// File: tb/tb_rect_index_gen.sv
// tb_rect_index_gen: directed self-checking bench for rect_index_gen
module tb_rect_index_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seed_load = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [31:0] seed = '0;
  logic [11:0] iter_count = '0;
  logic out_valid, busy, done;
  logic [2:0] r1, c1, r2, c2;
  logic [15:0] reject_cnt;
  logic t2_start = 1'b0, t2_valid, t2_busy, t2_done;
  logic [0:0] t2_r1, t2_c1, t2_r2, t2_c2;
  logic [15:0] t2_rej;
  logic t3_start = 1'b0, t3_valid, t3_busy, t3_done;
  logic [1:0] t3_r1, t3_c1, t3_r2, t3_c2;
  logic [15:0] t3_rej;
  int checks = 0, failures = 0;
  int hs;
  logic fin;
  logic [15:0] rej_end;
  logic [11:0] got [8];
  logic [11:0] first [4];
  logic [11:0] exp_seq [4];
  always #5 clk = ~clk;
  rect_index_gen #(.MATRIX_ROW(8), .MATRIX_COL(8)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
    .iter_count(iter_count), .out_valid(out_valid), .out_ready(out_ready),
    .r1(r1), .c1(c1), .r2(r2), .c2(c2), .busy(busy), .done(done), .reject_cnt(reject_cnt)
  );
  rect_index_gen #(.MATRIX_ROW(2), .MATRIX_COL(2)) dut2 (
    .clk(clk), .rst(rst), .seed_load(1'b0), .seed(32'd0), .start(t2_start),
    .iter_count(12'd5), .out_valid(t2_valid), .out_ready(1'b1),
    .r1(t2_r1), .c1(t2_c1), .r2(t2_r2), .c2(t2_c2), .busy(t2_busy), .done(t2_done), .reject_cnt(t2_rej)
  );
  rect_index_gen #(.MATRIX_ROW(3), .MATRIX_COL(3)) dut3 (
    .clk(clk), .rst(rst), .seed_load(1'b0), .seed(32'd0), .start(t3_start),
    .iter_count(12'd100), .out_valid(t3_valid), .out_ready(1'b1),
    .r1(t3_r1), .c1(t3_c1), .r2(t3_r2), .c2(t3_c2), .busy(t3_busy), .done(t3_done), .reject_cnt(t3_rej)
  );
  task automatic collect();
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (out_valid) begin
        if (hs < 8) got[hs] = {r1, c1, r2, c2};
        hs++;
      end
      if (done) begin
        rej_end = reject_cnt;
        fin = 1'b1;
      end else @(negedge clk);
    end
    out_ready = 1'b0;
  endtask
  task automatic run8(input logic [11:0] n);
    hs = 0;
    rej_end = '0;
    @(negedge clk);
    start = 1'b1;
    iter_count = n;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect();
  endtask
  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (reject_cnt !== 16'd0) begin failures++; $display("FAIL reset_rej got=%0d exp=0", reject_cnt); end
    checks++; if ({r1, c1, r2, c2} !== 12'd0) begin failures++; $display("FAIL reset_tuple got=%h exp=0", {r1, c1, r2, c2}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_zero_iter();
    @(negedge clk);
    start = 1'b1;
    iter_count = 12'd0;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, done, out_valid} !== 3'b110) begin failures++; $display("FAIL zero_iter_done got=%b exp=110", {busy, done, out_valid}); end
    @(negedge clk);
    checks++; if ({busy, done, out_valid} !== 3'b000) begin failures++; $display("FAIL zero_iter_idle got=%b exp=000", {busy, done, out_valid}); end
    checks++; if (reject_cnt !== 16'd0) begin failures++; $display("FAIL zero_iter_rej got=%0d exp=0", reject_cnt); end
  endtask
  task automatic test_backpressure();
    logic [11:0] held;
    int bad;
    @(negedge clk);
    start = 1'b1;
    iter_count = 12'd3;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
    held = {r1, c1, r2, c2};
    checks++; if (held !== exp_seq[0]) begin failures++; $display("FAIL bp_tuple0 got=%h exp=%h", held, exp_seq[0]); end
    checks++; if (reject_cnt !== 16'd1) begin failures++; $display("FAIL bp_rej0 got=%0d exp=1", reject_cnt); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || {r1, c1, r2, c2} !== held) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
    got[0] = held;
    hs = 1;
    out_ready = 1'b1;
    @(negedge clk);
    collect();
    checks++; if (!fin || hs != 3) begin failures++; $display("FAIL bp_count got=%0d fin=%b exp=3", hs, fin); end
    for (int k = 1; k < 3; k++) begin
      checks++; if (got[k] !== exp_seq[k]) begin failures++; $display("FAIL bp_tuple%0d got=%h exp=%h", k, got[k], exp_seq[k]); end
    end
    checks++; if (rej_end !== 16'd1) begin failures++; $display("FAIL bp_rej got=%0d exp=1", rej_end); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL bp_idle got=%b exp=00", {busy, done}); end
  endtask
  task automatic test_seed();
    @(negedge clk);
    seed_load = 1'b1;
    seed = 32'd0;
    start = 1'b1;
    iter_count = 12'd4;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seed_start_ignored got=%b exp=0", busy); end
    run8(12'd4);
    checks++; if (!fin || hs != 4) begin failures++; $display("FAIL seed0_count got=%0d fin=%b exp=4", hs, fin); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== exp_seq[k]) begin failures++; $display("FAIL seed0_tuple%0d got=%h exp=%h", k, got[k], exp_seq[k]); end
    end
    checks++; if (rej_end !== 16'd2) begin failures++; $display("FAIL seed0_rej got=%0d exp=2", rej_end); end
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      seed_load = 1'b1;
      seed = 32'h1;
      @(negedge clk);
      seed_load = 1'b0;
      run8(12'd4);
      checks++; if (!fin || hs != 4) begin failures++; $display("FAIL seed1_count%0d got=%0d fin=%b exp=4", p, hs, fin); end
      if (p == 0) for (int k = 0; k < 4; k++) first[k] = got[k];
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== first[k]) begin failures++; $display("FAIL seed1_repeat%0d got=%h exp=%h", k, got[k], first[k]); end
    end
  endtask
  task automatic test_2x2();
    int bad, last_hs, dcyc;
    @(negedge clk);
    t2_start = 1'b1;
    @(negedge clk);
    t2_start = 1'b0;
    hs = 0;
    bad = 0;
    last_hs = -10;
    dcyc = -1;
    for (int i = 0; i < 500 && dcyc < 0; i++) begin
      if (t2_valid) begin
        hs++;
        last_hs = i;
        if (t2_r1 == t2_r2 || t2_c1 == t2_c2) bad++;
      end
      if (t2_done) dcyc = i; else @(negedge clk);
    end
    checks++; if (hs != 5) begin failures++; $display("FAIL m2_count got=%0d exp=5", hs); end
    checks++; if (bad != 0) begin failures++; $display("FAIL m2_distinct got=%0d bad exp=0", bad); end
    checks++; if (dcyc != last_hs + 1) begin failures++; $display("FAIL m2_done_cycle got=%0d exp=%0d", dcyc, last_hs + 1); end
    @(negedge clk);
    checks++; if ({t2_busy, t2_done} !== 2'b00) begin failures++; $display("FAIL m2_idle got=%b exp=00", {t2_busy, t2_done}); end
  endtask
  task automatic test_3x3();
    int bad, draws;
    logic f3;
    @(negedge clk);
    t3_start = 1'b1;
    @(negedge clk);
    t3_start = 1'b0;
    hs = 0;
    bad = 0;
    draws = 0;
    f3 = 1'b0;
    for (int i = 0; i < 5000 && !f3; i++) begin
      if (t3_busy && !t3_valid && !t3_done) draws++;
      if (t3_valid) begin
        hs++;
        if (t3_r1 == 2'd3 || t3_r2 == 2'd3 || t3_c1 == 2'd3 || t3_c2 == 2'd3 || t3_r1 == t3_r2 || t3_c1 == t3_c2) bad++;
      end
      if (t3_done) f3 = 1'b1; else @(negedge clk);
    end
    checks++; if (!f3 || hs != 100) begin failures++; $display("FAIL m3_count got=%0d fin=%b exp=100", hs, f3); end
    checks++; if (bad != 0) begin failures++; $display("FAIL m3_range got=%0d bad exp=0", bad); end
    checks++; if (t3_rej == 16'd0) begin failures++; $display("FAIL m3_rej_nonzero got=0 exp>0"); end
    checks++; if (32'(t3_rej) != draws - hs) begin failures++; $display("FAIL m3_rej got=%0d exp=%0d", t3_rej, draws - hs); end
  endtask
  task automatic test_reset_mid_run();
    @(negedge clk);
    seed_load = 1'b1;
    seed = 32'd0;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b1;
    iter_count = 12'd4;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    checks++; if ({out_valid, r1, c1, r2, c2} !== {1'b1, exp_seq[1]}) begin failures++; $display("FAIL mid_tuple1 got=%h exp=%h", {out_valid, r1, c1, r2, c2}, {1'b1, exp_seq[1]}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL mid_async got=%b exp=000", {out_valid, busy, done}); end
    checks++; if (reject_cnt !== 16'd0) begin failures++; $display("FAIL mid_rej got=%0d exp=0", reject_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", done); end
    rst = 1'b0;
    run8(12'd4);
    checks++; if (!fin || hs != 4) begin failures++; $display("FAIL mid_rerun_count got=%0d fin=%b exp=4", hs, fin); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== exp_seq[k]) begin failures++; $display("FAIL mid_tuple%0d got=%h exp=%h", k, got[k], exp_seq[k]); end
    end
  endtask
  initial begin
    exp_seq[0] = {3'd4, 3'd2, 3'd0, 3'd6};
    exp_seq[1] = {3'd2, 3'd1, 3'd0, 3'd3};
    exp_seq[2] = {3'd5, 3'd4, 3'd4, 3'd5};
    exp_seq[3] = {3'd1, 3'd1, 3'd7, 3'd5};
    test_reset();
    test_zero_iter();
    test_backpressure();
    test_seed();
    test_2x2();
    test_3x3();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
